pe_feeder: RTL

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_pkg.sv | 25 ++
 rtl/pe_feed_buf.sv | 26 ++
 rtl/pe_feeder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand feeder: default widths, the
// active-low PE output-select encoding and the feeder state encoding.
package pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PSUM_W_DEF = 32;

    // The PE drives pe_opsum_seln low when pe_opsum holds a finished result
    localparam logic SELN_VALID = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_FEED = 3'd3,
        ST_WAIT = 3'd4,
        ST_OUT  = 3'd5
    } feeder_state_t;

    // A job is legal only when it fits the operand buffer and has at least one MAC
    function automatic logic kernel_ok(input logic [7:0] k, input int depth);
        return (k != 8'd0) && (int'(k) <= depth);
    endfunction

endpackage

// File: rtl/pe_feed_buf.sv
// Operand pair buffer: DEPTH entries of {act, wgt}, one synchronous write
// port and one combinational read port. Contents are not reset.
module pe_feed_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [2*DATA_W-1:0] rdata
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_feeder.sv
// Collects K activation/weight pairs, arms the PE with one enable pulse,
// streams the pairs to it and returns the PE partial sum over a handshake.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        kernel_size,
    input  logic [PSUM_W-1:0] ipsum_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_wgt,
    output logic              pe_en,
    output logic [PSUM_W-1:0] pe_ipsum,
    output logic [DATA_W-1:0] pe_act,
    output logic [DATA_W-1:0] pe_wgt,
    input  logic [PSUM_W-1:0] pe_opsum,
    input  logic              pe_opsum_seln,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PSUM_W-1:0] res_data,
    output logic              busy,
    output logic              err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    feeder_state_t       state;
    logic [7:0]          k_reg;
    logic [7:0]          k_last;
    logic [PSUM_W-1:0]   ipsum_reg;
    logic [7:0]          wr_ptr;
    logic [7:0]          rd_ptr;
    logic [7:0]          wait_cnt;
    logic [8:0]          wait_limit;
    logic [DATA_W-1:0]   act_q;
    logic [DATA_W-1:0]   wgt_q;
    logic [PSUM_W-1:0]   res_q;
    logic                err_q;
    logic                wr_en;
    logic [2*DATA_W-1:0] rd_pair;

    // k_reg is never 0 outside IDLE, so k_last cannot underflow where it is used
    assign k_last     = k_reg - 8'd1;
    assign wait_limit = {1'b0, k_reg} + 9'd4;
    assign wr_en      = (state == ST_LOAD) && in_valid;

    pe_feed_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (AW'(wr_ptr)),
        .wdata ({in_act, in_wgt}),
        .raddr (AW'(rd_ptr)),
        .rdata (rd_pair)
    );

    // Operands are registered so entry i appears two cycles after the enable
    // pulse plus i; outside FEED they fall back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_reg     <= 8'd0;
            ipsum_reg <= '0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            wait_cnt  <= 8'd0;
            act_q     <= '0;
            wgt_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            act_q <= '0;
            wgt_q <= '0;
            case (state)
                ST_IDLE: begin
                    wr_ptr   <= 8'd0;
                    rd_ptr   <= 8'd0;
                    wait_cnt <= 8'd0;
                    if (start) begin
                        if (kernel_ok(kernel_size, DEPTH)) begin
                            k_reg     <= kernel_size;
                            ipsum_reg <= ipsum_in;
                            state     <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        wr_ptr <= wr_ptr + 8'd1;
                        if (wr_ptr == k_last) begin
                            state <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    act_q  <= rd_pair[2*DATA_W-1:DATA_W];
                    wgt_q  <= rd_pair[DATA_W-1:0];
                    rd_ptr <= rd_ptr + 8'd1;
                    if (rd_ptr == k_last) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pe_opsum_seln == SELN_VALID) begin
                        res_q <= pe_opsum;
                        state <= ST_OUT;
                    end else if ({1'b0, wait_cnt} == wait_limit) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_LOAD);
    assign pe_en     = (state == ST_ARM);
    assign pe_ipsum  = (state == ST_ARM || state == ST_FEED ||
                        state == ST_WAIT || state == ST_OUT) ? ipsum_reg : '0;
    assign pe_act    = act_q;
    assign pe_wgt    = wgt_q;
    assign res_valid = (state == ST_OUT);
    assign res_data  = res_q;
    assign busy      = (state != ST_IDLE);
    assign err       = err_q;

endmodule
